// File: rtl/mem_pkg.sv
// Shared memory-access types: access widths and arbiter state encodings.
// Used by the arbiter, CPU and UART blocks alike.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_ACC_8  = 2'b00,
        MEM_ACC_16 = 2'b01,
        MEM_ACC_32 = 2'b10
    } mem_acc_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    // Index width that stays legal for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the memory arbiter.
// slave = arbiter view; master = requesters plus downstream memory.
interface mem_arbiter_if #(
    parameter int M_WIDTH = 32,
    parameter int N_REQ   = 2
);
    import mem_pkg::*;

    localparam int ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]         req_req;
    logic [N_REQ-1:0]         req_we;
    logic [N_REQ*M_WIDTH-1:0] req_addr;
    logic [N_REQ*2-1:0]       req_width;
    logic [N_REQ*M_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]         req_ready;
    logic [M_WIDTH-1:0]       req_rdata;

    logic                     mem_req;
    logic                     mem_we;
    logic [M_WIDTH-1:0]       mem_addr;
    logic [1:0]               mem_width;
    logic [M_WIDTH-1:0]       mem_wdata;
    logic                     mem_ready;
    logic [M_WIDTH-1:0]       mem_rdata;

    logic [ID_W-1:0]          grant_id;
`ifdef MEM_ARB_TIMEOUT_EN
    logic                     arb_timeout;
`endif

    modport slave (
        input  req_req, req_we, req_addr, req_width, req_wdata,
        input  mem_ready, mem_rdata,
        output
`ifdef MEM_ARB_TIMEOUT_EN
               arb_timeout,
`endif
               req_ready, req_rdata,
               mem_req, mem_we, mem_addr, mem_width, mem_wdata, grant_id
    );

    modport master (
        output req_req, req_we, req_addr, req_width, req_wdata,
        output mem_ready, mem_rdata,
        input
`ifdef MEM_ARB_TIMEOUT_EN
               arb_timeout,
`endif
               req_ready, req_rdata,
               mem_req, mem_we, mem_addr, mem_width, mem_wdata, grant_id
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin winner select, searching upward from last+1 with wrap.
// Purely combinational; no handshake of its own.
module rr_pick #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    logic [ID_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ID_W'((int'(last) + k) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port; 3-cycle minimum occupancy (IDLE, ISSUE, RESP).
// Holds mem_* stable until mem_ready; optional ISSUE timeout under MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int M_WIDTH = 32,
    parameter int N_REQ   = 2
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int              ID_W     = id_width(N_REQ);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

    typedef struct packed {
        logic               we;
        logic [1:0]         width;
        logic [M_WIDTH-1:0] addr;
        logic [M_WIDTH-1:0] wdata;
    } cmd_t;

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    grant_id_q;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_vld;
    cmd_t               cmd_sel;
    cmd_t               cmd_q;
    logic               mem_req_q;
    logic [M_WIDTH-1:0] rdata_q;
    logic [N_REQ-1:0]   ready_q;
    logic               do_grant;
    logic               do_done;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0]        to_cnt_q;
    logic               do_timeout;
    logic               timeout_q;
`endif

    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req   (bus.req_req),
        .last  (last_grant_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_comb begin
        cmd_sel.we    = bus.req_we[pick_idx];
        cmd_sel.width = bus.req_width[pick_idx*2 +: 2];
        cmd_sel.addr  = bus.req_addr[pick_idx*M_WIDTH +: M_WIDTH];
        cmd_sel.wdata = bus.req_wdata[pick_idx*M_WIDTH +: M_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RESP always falls back to IDLE so the requester's late request drop is never re-granted.
    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_done  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        do_timeout = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    do_grant = 1'b1;
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.mem_ready) begin
                    do_done = 1'b1;
                    state_d = ARB_RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (to_cnt_q + 16'd1 >= TO_LIM) begin
                    do_done    = 1'b1;
                    do_timeout = 1'b1;
                    state_d    = ARB_RESP;
                end
`endif
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q        <= '{we: 1'b0, width: MEM_ACC_8, addr: '0, wdata: '0};
            mem_req_q    <= 1'b0;
            rdata_q      <= '0;
            ready_q      <= '0;
            grant_id_q   <= '0;
            last_grant_q <= LAST_RST;
        end else begin
            ready_q <= '0;
            if (do_grant) begin
                cmd_q        <= cmd_sel;
                mem_req_q    <= 1'b1;
                grant_id_q   <= pick_idx;
                last_grant_q <= pick_idx;
            end
            if (do_done) begin
                mem_req_q <= 1'b0;
                rdata_q   <= bus.mem_rdata;
                ready_q   <= N_REQ'(1) << grant_id_q;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            // A timed-out read returns zero rather than whatever sits on mem_rdata.
            if (do_timeout) begin
                rdata_q <= '0;
            end
`endif
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= do_timeout;
            if (do_grant) begin
                to_cnt_q <= '0;
            end else if (state_q == ARB_ISSUE) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
        end
    end

    assign bus.arb_timeout = timeout_q;
`endif

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = cmd_q.we;
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_width = cmd_q.width;
    assign bus.mem_wdata = cmd_q.wdata;
    assign bus.req_ready = ready_q;
    assign bus.req_rdata = rdata_q;
    assign bus.grant_id  = grant_id_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter M_WIDTH, default 32, address and data width.
REQ-002 Parameter N_REQ, default 2, number of requesters; requester 0 is the CPU and requester 1 is the UART TX fetch.
REQ-003 Port clk, input, 1, single clock; all state is updated on the rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port req_req, input, N_REQ, per-requester request level, held until that requester's ready.
REQ-006 Port req_we, input, N_REQ, per-requester write enable.
REQ-007 Port req_addr, input, N_REQ*M_WIDTH, packed addresses; requester i occupies slice i.
REQ-008 Port req_width, input, N_REQ*2, packed access widths: MEM_ACC_8, MEM_ACC_16 or MEM_ACC_32.
REQ-009 Port req_wdata, input, N_REQ*M_WIDTH, packed write data.
REQ-010 Port req_ready, output, N_REQ, one-hot single-cycle completion pulse.
REQ-011 Port req_rdata, output, M_WIDTH, read data shared by all requesters; valid with req_ready.
REQ-012 Port mem_req, mem_we, mem_addr, mem_width, mem_wdata, outputs, 1/1/M_WIDTH/2/M_WIDTH, downstream memory port.
REQ-013 Port mem_ready, input, 1, downstream completion; mem_rdata, input, M_WIDTH, valid with mem_ready.
REQ-014 Port grant_id, output, clog2(N_REQ), index of the current or last granted requester.

Function
REQ-015 States are IDLE, ISSUE and RESP, encoded in a 2-bit register.
REQ-016 IDLE, no req_req bit set: the block stays in IDLE.
REQ-017 IDLE, any req_req bit set: the block selects one winner (REQ-024), latches that winner's we/addr/width/wdata into the mem_* registers, sets mem_req=1 and goes to ISSUE on the same edge.
REQ-018 ISSUE: all mem_* outputs are held stable while mem_ready=0.
REQ-019 ISSUE, mem_ready=1: on that edge the block clears mem_req, captures mem_rdata into req_rdata, sets req_ready[grant_id]=1 and goes to RESP.
REQ-020 RESP: the block lasts exactly one cycle, clears req_ready, ignores all req_req and returns to IDLE; this absorbs the requester's one-cycle request drop latency.
REQ-021 Minimum transaction occupancy is 3 cycles: IDLE sample, ISSUE with mem_ready at 0 wait, RESP.
REQ-022 req_rdata holds its value until the next mem_ready capture; for writes it takes the value of mem_rdata as well.
REQ-023 A requester that drops req_req during ISSUE does not abort the transaction; it completes and a ready pulse is still issued.
REQ-024 Winner selection is round-robin: search from (last_grant+1) mod N_REQ upward with wrap; last_grant updates on each grant.
REQ-025 A mem_ready received outside ISSUE is ignored and generates no req_ready.
REQ-026 Simultaneous requests in IDLE are resolved by REQ-024; at most one req_ready bit is ever set.

Reset
REQ-027 rst=1 asynchronously forces state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_width=MEM_ACC_8, mem_wdata=0, req_ready=0, req_rdata=0, grant_id=0 and last_grant=N_REQ-1, so requester 0 wins first.
REQ-028 Reset asserted mid-transaction abandons the transaction; no req_ready pulse is issued after release.

Configuration
REQ-029 Macro MEM_ARB_TIMEOUT_EN.
REQ-030 With MEM_ARB_TIMEOUT_EN defined, a 16-bit counter increments each ISSUE cycle; on reaching TIMEOUT_CYCLES (parameter, default 1024) the block ends the transaction as if mem_ready had arrived, sets req_rdata=0, pulses output arb_timeout for one cycle, pulses req_ready[grant_id] and goes to RESP.
REQ-031 Without MEM_ARB_TIMEOUT_EN, neither the counter nor the arb_timeout port exists, and ISSUE waits indefinitely.

Structure
REQ-032 MEM_ACC_8/16/32 and the state encodings live in the shared package mem_pkg, which the UART and CPU also use.
REQ-033 Winner selection lives in one combinational sub-module, rr_pick, with inputs req and last and outputs valid and idx.

Verification
REQ-034 Reset release, then req_req=2'b01, addr=0x100, mem_ready returned 2 cycles after mem_req -> mem_addr=0x100, req_ready=2'b01 for exactly 1 cycle, req_rdata=mem_rdata.
REQ-035 req_req=2'b11 held continuously -> grants alternate 0,1,0,1 and grant_id follows the same sequence.
REQ-036 Requester 1 issues a byte read at 0x2000 with width MEM_ACC_8 -> mem_width=2'b00, mem_we=0, and mem_addr stays stable for 5 wait cycles.
REQ-037 rst pulsed during ISSUE -> mem_req drops immediately, and req_ready stays 0 afterwards.
REQ-038 Built with MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready tied 0 -> arb_timeout and req_ready pulse after 8 ISSUE cycles with req_rdata=0; built without the macro -> no pulse after 100 cycles.
REQ-039 mem_ready pulsed while in IDLE -> no req_ready, and the state stays IDLE.
